// File: rtl/forwarding_hazard_unit.sv
// ---------------------------------------------------------------------------
// forwarding_hazard_unit
//
// Purpose:
//   Producer side of the EX-stage forwarding interface.
//   - Follows the destination registers of the instructions now in EX, MEM
//     and WB. MEM and WB are kept in an internal shadow pipeline.
//   - Computes the forwarding selects for the instruction in ID and
//     registers them at the ID->EX edge, so EX uses them one cycle later.
//   - Detects load-use hazards and inserts a single-cycle stall plus a
//     bubble in ID/EX.
//   - Flushes IF/ID and ID/EX when a taken branch resolves.
//   - Counts stall cycles in a saturating counter.
//
// Select encoding:
//   000  register file
//   001  EX/MEM result
//   010  MEM/WB write data
//
// Ports:
//   i_clk, i_reset          clock; asynchronous active-high reset
//   i_halt                  freezes all state; forces the stall/flush outputs low
//   i_id_rs, i_id_rt        source registers of the instruction in ID
//   i_id_uses_rt            the ID instruction reads rt as a source
//   i_ex_rd                 destination register of the instruction in EX
//   i_ex_reg_write          the EX instruction writes the register file
//   i_ex_mem_read           the EX instruction is a load
//   i_branch_taken          a taken branch resolved in EX this cycle
//   o_corto_register_A/B    registered forwarding selects for ALU operands A and B
//   o_stall                 hold PC and IF/ID (combinational)
//   o_flush_ifid            clear IF/ID (combinational)
//   o_flush_idex            load a bubble into ID/EX (combinational)
//   o_stall_count           saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module forwarding_hazard_unit #(
    parameter int BITS_REGS          = 5,
    parameter int BITS_CORTOCIRCUITO = 3,
    parameter int BITS_COUNT         = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_halt,
    input  logic [BITS_REGS-1:0]          i_id_rs,
    input  logic [BITS_REGS-1:0]          i_id_rt,
    input  logic                          i_id_uses_rt,
    input  logic [BITS_REGS-1:0]          i_ex_rd,
    input  logic                          i_ex_reg_write,
    input  logic                          i_ex_mem_read,
    input  logic                          i_branch_taken,
    output logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_A,
    output logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_B,
    output logic                          o_stall,
    output logic                          o_flush_ifid,
    output logic                          o_flush_idex,
    output logic [BITS_COUNT-1:0]         o_stall_count
);

    localparam logic [BITS_CORTOCIRCUITO-1:0] SEL_RF    = BITS_CORTOCIRCUITO'(0);
    localparam logic [BITS_CORTOCIRCUITO-1:0] SEL_EXMEM = BITS_CORTOCIRCUITO'(1);
    localparam logic [BITS_CORTOCIRCUITO-1:0] SEL_MEMWB = BITS_CORTOCIRCUITO'(2);

    typedef enum logic {
        RUN,
        LOAD_STALL
    } state_t;

    state_t                          state;
    state_t                          state_next;
    logic [BITS_REGS-1:0]            mem_rd;
    logic                            mem_wr;
    logic [BITS_REGS-1:0]            wb_rd;
    logic                            wb_wr;
    logic [BITS_CORTOCIRCUITO-1:0]   sel_a;
    logic [BITS_CORTOCIRCUITO-1:0]   sel_b;
    logic                            hazard;

    // Picks the forwarding source for one operand. The youngest producer wins,
    // so an EX match beats a MEM match. A WB match maps to the register file
    // because the register file writes before it reads. Register 0 never
    // forwards.
    function automatic logic [BITS_CORTOCIRCUITO-1:0] select_for(
        input logic [BITS_REGS-1:0] r,
        input logic                 used,
        input logic [BITS_REGS-1:0] ex_rd,
        input logic                 ex_wr,
        input logic [BITS_REGS-1:0] m_rd,
        input logic                 m_wr,
        input logic [BITS_REGS-1:0] w_rd,
        input logic                 w_wr
    );
        if (!used || r == '0)        return SEL_RF;
        if (ex_wr && ex_rd == r)     return SEL_EXMEM;
        if (m_wr && m_rd == r)       return SEL_MEMWB;
        if (w_wr && w_rd == r)       return SEL_RF;
        return SEL_RF;
    endfunction

    // Forwarding selects for the instruction in ID, and detection of a
    // load-use hazard against the load now in EX.
    always_comb begin
        sel_a  = select_for(i_id_rs, 1'b1, i_ex_rd, i_ex_reg_write,
                            mem_rd, mem_wr, wb_rd, wb_wr);
        sel_b  = select_for(i_id_rt, i_id_uses_rt, i_ex_rd, i_ex_reg_write,
                            mem_rd, mem_wr, wb_rd, wb_wr);
        hazard = i_ex_mem_read && i_ex_reg_write && (i_ex_rd != '0) &&
                 ((i_ex_rd == i_id_rs) || (i_id_uses_rt && (i_ex_rd == i_id_rt)));
    end

    // Next-state logic and stall/flush outputs.
    // - A taken branch overrides a load-use hazard and returns the FSM to RUN.
    // - In LOAD_STALL the bubble already sits in EX, so the FSM never stalls
    //   twice for the same load.
    always_comb begin
        state_next   = state;
        o_stall      = 1'b0;
        o_flush_ifid = 1'b0;
        o_flush_idex = 1'b0;
        if (!i_halt) begin
            if (i_branch_taken) begin
                o_flush_ifid = 1'b1;
                o_flush_idex = 1'b1;
                state_next   = RUN;
            end else begin
                case (state)
                    RUN: begin
                        if (hazard) begin
                            o_stall      = 1'b1;
                            o_flush_idex = 1'b1;
                            state_next   = LOAD_STALL;
                        end
                    end
                    LOAD_STALL: state_next = RUN;
                    default:    state_next = RUN;
                endcase
            end
        end
    end

    // State register, shadow MEM/WB pipeline, registered selects and stall
    // counter.
    // - Halt freezes everything.
    // - A bubble in ID/EX carries register-file selects.
    // - The counter stops at all-ones instead of wrapping.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state              <= RUN;
            mem_rd             <= '0;
            mem_wr             <= 1'b0;
            wb_rd              <= '0;
            wb_wr              <= 1'b0;
            o_corto_register_A <= SEL_RF;
            o_corto_register_B <= SEL_RF;
            o_stall_count      <= '0;
        end else if (!i_halt) begin
            state  <= state_next;
            wb_rd  <= mem_rd;
            wb_wr  <= mem_wr;
            mem_rd <= i_ex_rd;
            mem_wr <= i_ex_reg_write;
            if (o_flush_idex) begin
                o_corto_register_A <= SEL_RF;
                o_corto_register_B <= SEL_RF;
            end else begin
                o_corto_register_A <= sel_a;
                o_corto_register_B <= sel_b;
            end
            if (o_stall && (o_stall_count != '1))
                o_stall_count <= o_stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_forwarding_hazard_unit
//
// Drives one ID/EX cycle at a time. Each step:
//   1. Checks the combinational stall/flush outputs against a reference
//      model straight away.
//   2. Pushes the expected registered selects and counter value into a
//      queue.
//   3. After the next rising edge, pops that entry and compares it with
//      the DUT.
// ---------------------------------------------------------------------------
module tb_forwarding_hazard_unit;

    logic        i_clk;
    logic        i_reset;
    logic        i_halt;
    logic [4:0]  i_id_rs;
    logic [4:0]  i_id_rt;
    logic        i_id_uses_rt;
    logic [4:0]  i_ex_rd;
    logic        i_ex_reg_write;
    logic        i_ex_mem_read;
    logic        i_branch_taken;
    logic [2:0]  o_corto_register_A;
    logic [2:0]  o_corto_register_B;
    logic        o_stall;
    logic        o_flush_ifid;
    logic        o_flush_idex;
    logic [15:0] o_stall_count;

    typedef struct {
        logic [2:0]  sel_a;
        logic [2:0]  sel_b;
        logic [15:0] count;
    } expect_t;

    expect_t scoreboard[$];

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state
    logic [4:0]  m_mem_rd;
    logic        m_mem_wr;
    logic        m_in_stall;
    logic [15:0] m_count;
    logic        e_stall;
    logic        e_flush_ifid;
    logic        e_flush_idex;

    forwarding_hazard_unit #(
        .BITS_REGS(5),
        .BITS_CORTOCIRCUITO(3),
        .BITS_COUNT(16)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_halt(i_halt),
        .i_id_rs(i_id_rs),
        .i_id_rt(i_id_rt),
        .i_id_uses_rt(i_id_uses_rt),
        .i_ex_rd(i_ex_rd),
        .i_ex_reg_write(i_ex_reg_write),
        .i_ex_mem_read(i_ex_mem_read),
        .i_branch_taken(i_branch_taken),
        .o_corto_register_A(o_corto_register_A),
        .o_corto_register_B(o_corto_register_B),
        .o_stall(o_stall),
        .o_flush_ifid(o_flush_ifid),
        .o_flush_idex(o_flush_idex),
        .o_stall_count(o_stall_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Forwarding source expected for one operand
    function automatic logic [2:0] modelSelect(input logic [4:0] r, input logic used);
        logic [2:0] s;
        s = 3'b000;
        if (used && r != 5'd0) begin
            if (i_ex_reg_write && i_ex_rd == r)
                s = 3'b001;
            else if (m_mem_wr && m_mem_rd == r)
                s = 3'b010;
        end
        return s;
    endfunction

    // Expected combinational outputs for the current inputs and model state
    task automatic modelComb();
        logic hz;
        hz = i_ex_mem_read && i_ex_reg_write && (i_ex_rd != 5'd0) &&
             ((i_ex_rd == i_id_rs) || (i_id_uses_rt && (i_ex_rd == i_id_rt)));
        e_stall      = 1'b0;
        e_flush_ifid = 1'b0;
        e_flush_idex = 1'b0;
        if (!i_halt) begin
            if (i_branch_taken) begin
                e_flush_ifid = 1'b1;
                e_flush_idex = 1'b1;
            end else if (!m_in_stall && hz) begin
                e_stall      = 1'b1;
                e_flush_idex = 1'b1;
            end
        end
    endtask

    task automatic modelReset();
        m_mem_rd   = 5'd0;
        m_mem_wr   = 1'b0;
        m_in_stall = 1'b0;
        m_count    = 16'd0;
    endtask

    task automatic applyStimulus(input string name,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                                 input logic [4:0] ex_rd, input logic ex_wr, input logic ex_mr,
                                 input logic br, input logic halt);
        expect_t e;
        expect_t got;
        i_id_rs        = rs;
        i_id_rt        = rt;
        i_id_uses_rt   = uses_rt;
        i_ex_rd        = ex_rd;
        i_ex_reg_write = ex_wr;
        i_ex_mem_read  = ex_mr;
        i_branch_taken = br;
        i_halt         = halt;
        #1;
        modelComb();
        checkOutput({name, ".stall"},      32'(o_stall),      32'(e_stall));
        checkOutput({name, ".flush_ifid"}, 32'(o_flush_ifid), 32'(e_flush_ifid));
        checkOutput({name, ".flush_idex"}, 32'(o_flush_idex), 32'(e_flush_idex));

        if (!halt) begin
            e.sel_a    = e_flush_idex ? 3'b000 : modelSelect(rs, 1'b1);
            e.sel_b    = e_flush_idex ? 3'b000 : modelSelect(rt, uses_rt);
            if (e_stall && m_count != 16'hFFFF)
                m_count = m_count + 16'd1;
            m_in_stall = e_stall;
            m_mem_rd   = ex_rd;
            m_mem_wr   = ex_wr;
        end else begin
            e.sel_a = o_corto_register_A;
            e.sel_b = o_corto_register_B;
        end
        e.count = m_count;
        scoreboard.push_back(e);

        @(posedge i_clk);
        #1;
        got = scoreboard.pop_front();
        checkOutput({name, ".sel_A"}, 32'(o_corto_register_A), 32'(got.sel_a));
        checkOutput({name, ".sel_B"}, 32'(o_corto_register_B), 32'(got.sel_b));
        checkOutput({name, ".count"}, 32'(o_stall_count),      32'(got.count));
    endtask

    initial begin
        expect_t held;
        i_reset        = 1'b1;
        i_halt         = 1'b0;
        i_id_rs        = 5'd0;
        i_id_rt        = 5'd0;
        i_id_uses_rt   = 1'b0;
        i_ex_rd        = 5'd0;
        i_ex_reg_write = 1'b0;
        i_ex_mem_read  = 1'b0;
        i_branch_taken = 1'b0;
        modelReset();
        #12;
        checkOutput("reset.sel_A", 32'(o_corto_register_A), 32'd0);
        checkOutput("reset.sel_B", 32'(o_corto_register_B), 32'd0);
        checkOutput("reset.count", 32'(o_stall_count), 32'd0);
        checkOutput("reset.stall", 32'(o_stall), 32'd0);
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;

        //             name         rs    rt    ut  exrd  wr mr br ht
        applyStimulus("ex_fwd_a",   5'd3, 5'd4, 1, 5'd3, 1, 0, 0, 0);
        applyStimulus("mem_fwd_b",  5'd1, 5'd3, 1, 5'd7, 1, 0, 0, 0);
        applyStimulus("prep_ex3",   5'd0, 5'd0, 0, 5'd3, 1, 0, 0, 0);
        applyStimulus("ex_over_mem",5'd3, 5'd3, 1, 5'd3, 1, 0, 0, 0);
        applyStimulus("reg0_nofwd", 5'd0, 5'd3, 0, 5'd0, 1, 0, 0, 0);
        applyStimulus("lw_stall",   5'd5, 5'd0, 0, 5'd5, 1, 1, 0, 0);
        applyStimulus("lw_bubble",  5'd5, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        applyStimulus("lw_branch",  5'd1, 5'd6, 1, 5'd6, 1, 1, 1, 0);
        applyStimulus("lw_rt_unused",5'd2, 5'd6, 0, 5'd6, 1, 1, 0, 0);
        applyStimulus("lw_rd0",     5'd0, 5'd0, 1, 5'd0, 1, 1, 0, 0);
        applyStimulus("lw_rt_stall",5'd1, 5'd9, 1, 5'd9, 1, 1, 0, 0);
        applyStimulus("no_restall", 5'd1, 5'd9, 1, 5'd9, 1, 1, 0, 0);
        applyStimulus("stall_again",5'd9, 5'd0, 0, 5'd9, 1, 1, 0, 0);

        // Asynchronous reset while in LOAD_STALL, with hazard inputs still applied
        i_reset = 1'b1;
        #1;
        modelReset();
        modelComb();
        checkOutput("midrst.sel_A", 32'(o_corto_register_A), 32'd0);
        checkOutput("midrst.sel_B", 32'(o_corto_register_B), 32'd0);
        checkOutput("midrst.count", 32'(o_stall_count), 32'd0);
        checkOutput("midrst.stall_run", 32'(o_stall), 32'(e_stall));
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        applyStimulus("post_rst_stall", 5'd9, 5'd0, 0, 5'd9, 1, 1, 0, 0);
        applyStimulus("post_rst_bub",   5'd9, 5'd0, 0, 5'd0, 0, 0, 0, 0);

        // Halt freezes selects, counter and shadow pipe
        applyStimulus("pre_halt", 5'd3, 5'd0, 0, 5'd3, 1, 0, 0, 0);
        held.sel_a = o_corto_register_A;
        held.sel_b = o_corto_register_B;
        held.count = o_stall_count;
        checkOutput("pre_halt.sel_A_nonzero", 32'(o_corto_register_A), 32'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus($sformatf("halt%0d", i), 5'd8, 5'd8, 1, 5'd8, 1, i[0], i[1], 1);
        end
        checkOutput("halt.sel_A_hold", 32'(o_corto_register_A), 32'(held.sel_a));
        checkOutput("halt.count_hold", 32'(o_stall_count), 32'(held.count));
        applyStimulus("post_halt_mem", 5'd3, 5'd0, 0, 5'd0, 0, 0, 0, 0);

        // Random traffic on a small register range to provoke matches
        for (int i = 0; i < 60; i++) begin
            applyStimulus($sformatf("rnd%0d", i),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
